// File: rtl/binary_to_bcd_seq_if.sv
// Handshake/result bundle for binary_to_bcd_seq.
// master = requester (drives start/bin_in), slave = converter.
// Optional macro SIGNED_INPUT_EN adds the neg result bit.
interface binary_to_bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;
`ifdef SIGNED_INPUT_EN
    logic                  neg;

    modport master (output start, bin_in, input busy, done, bcd_out, overflow, neg);
    modport slave  (input start, bin_in, output busy, done, bcd_out, overflow, neg);
`else
    modport master (output start, bin_in, input busy, done, bcd_out, overflow);
    modport slave  (input start, bin_in, output busy, done, bcd_out, overflow);
`endif
endinterface

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// IDLE -> SHIFT (WIDTH steps) -> DONE_ST (one-cycle done pulse) -> IDLE.
// Optional macro SIGNED_INPUT_EN: bin_in is two's complement, the magnitude
// is converted and the sign is reported on bus.neg.
module binary_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    binary_to_bcd_seq_if.slave    bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE_ST} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [BW-1:0]    acc_q, acc_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;          // sticky carry out of top digit
    logic             ovf_out_q, ovf_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [BW-1:0]    acc_adj;
    logic [BW:0]      acc_shl;               // [BW] is the bit leaving the top digit
    logic [WIDTH-1:0] cap_val;

`ifdef SIGNED_INPUT_EN
    logic             neg_cap_q, neg_cap_d;
    logic             neg_q, neg_d;

    // Magnitude as unsigned WIDTH bits so the most negative value still fits.
    always_comb begin
        cap_val = bus.bin_in[WIDTH-1] ? (WIDTH'(0) - bus.bin_in) : bus.bin_in;
    end
`else
    // Unsigned operand is captured as-is.
    always_comb begin
        cap_val = bus.bin_in;
    end
`endif

    // Add-3 correction on every digit in parallel, then shift in the next operand bit.
    always_comb begin
        acc_adj = acc_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5)
                acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
        end
        acc_shl = {acc_adj, opnd_q[WIDTH-1]};
    end

    // Next-state and datapath control; results only move on the final shift.
    always_comb begin
        state_d   = state_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;
        ovf_out_d = ovf_out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef SIGNED_INPUT_EN
        neg_cap_d = neg_cap_q;
        neg_d     = neg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    opnd_d  = cap_val;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
`ifdef SIGNED_INPUT_EN
                    neg_cap_d = bus.bin_in[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                acc_d  = acc_shl[BW-1:0];
                opnd_d = {opnd_q[WIDTH-2:0], 1'b0};
                ovf_d  = ovf_q | acc_shl[BW];
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    bcd_d     = acc_shl[BW-1:0];
                    ovf_out_d = ovf_q | acc_shl[BW];
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE_ST;
`ifdef SIGNED_INPUT_EN
                    neg_d     = neg_cap_q;
`endif
                end
            end
            DONE_ST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            ovf_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SIGNED_INPUT_EN
            neg_cap_q <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
            ovf_out_q <= ovf_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SIGNED_INPUT_EN
            neg_cap_q <= neg_cap_d;
            neg_q     <= neg_d;
`endif
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_out_q;
`ifdef SIGNED_INPUT_EN
    assign bus.neg      = neg_q;
`endif

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Bench for binary_to_bcd_seq: a 3-digit and a 2-digit instance (WIDTH=8)
// share the same stimulus; expected results come from an integer model.
module tb_binary_to_bcd_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    binary_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) b3 ();
    binary_to_bcd_seq_if #(.WIDTH(8), .DIGITS(2)) b2 ();

    assign b2.start  = b3.start;
    assign b2.bin_in = b3.bin_in;

    binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
    binary_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    typedef struct {
        logic [11:0] bcd3;
        logic        ovf3;
        logic [7:0]  bcd2;
        logic        ovf2;
        logic        neg;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t model(input logic [7:0] v);
        exp_t e;
        int   m, t;
`ifdef SIGNED_INPUT_EN
        e.neg = v[7];
        m = v[7] ? 256 - int'(v) : int'(v);
`else
        e.neg = 1'b0;
        m = int'(v);
`endif
        e.ovf3 = (m >= 1000);
        e.ovf2 = (m >= 100);
        e.bcd3 = '0;
        e.bcd2 = '0;
        t = m;
        for (int k = 0; k < 3; k++) begin e.bcd3[4*k +: 4] = 4'(t % 10); t = t / 10; end
        t = m;
        for (int k = 0; k < 2; k++) begin e.bcd2[4*k +: 4] = 4'(t % 10); t = t / 10; end
        return e;
    endfunction

    // Starts one conversion at the current negedge and observes it; returns at
    // the negedge after done (or after the cycle budget expires).
    task automatic do_conv(input logic [7:0] v, output int done_at, output int busy_cnt,
                           output bit held, output exp_t got);
        logic [11:0] prev3;
        prev3 = b3.bcd_out;
        got.bcd3 = 'x; got.ovf3 = 'x; got.bcd2 = 'x; got.ovf2 = 'x; got.neg = 'x;
        b3.start  = 1'b1;
        b3.bin_in = v;
        sb.push_back(model(v));
        @(negedge clk);
        b3.start  = 1'b0;
        b3.bin_in = 8'($urandom);
        done_at = -1; busy_cnt = 0; held = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            if (b3.busy) busy_cnt++;
            if (b3.done && done_at < 0) begin
                done_at  = i;
                got.bcd3 = b3.bcd_out; got.ovf3 = b3.overflow;
                got.bcd2 = b2.bcd_out; got.ovf2 = b2.overflow;
`ifdef SIGNED_INPUT_EN
                got.neg  = b3.neg;
`else
                got.neg  = 1'b0;
`endif
            end else if (done_at < 0 && b3.bcd_out !== prev3) begin
                held = 1'b0;
            end
            if (done_at >= 0 && i == done_at + 1) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        checks++; if (b3.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", b3.busy); end
        checks++; if (b3.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", b3.done); end
        checks++; if (b3.bcd_out !== 12'h000) begin errors++; $display("FAIL reset_bcd3 got=%h want=000", b3.bcd_out); end
        checks++; if (b3.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf3 got=%b want=0", b3.overflow); end
        checks++; if (b2.bcd_out !== 8'h00 || b2.busy !== 1'b0) begin errors++; $display("FAIL reset_dut2 got=%h/%b want=00/0", b2.bcd_out, b2.busy); end
`ifdef SIGNED_INPUT_EN
        checks++; if (b3.neg !== 1'b0) begin errors++; $display("FAIL reset_neg got=%b want=0", b3.neg); end
`endif
    endtask

    task automatic test_basic;
        int done_at, busy_cnt; bit held; exp_t got, e;
        do_conv(8'd255, done_at, busy_cnt, held, got);
        e = sb.pop_front();
        checks++; if (done_at !== 9) begin errors++; $display("FAIL basic_latency got=%0d want=9", done_at); end
        checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL basic_busy_cycles got=%0d want=8", busy_cnt); end
        checks++; if (!held) begin errors++; $display("FAIL basic_hold got=changed want=held"); end
        checks++; if ({got.bcd3, got.ovf3} !== {e.bcd3, e.ovf3}) begin errors++; $display("FAIL basic_d3 got=%h/%b want=%h/%b", got.bcd3, got.ovf3, e.bcd3, e.ovf3); end
        checks++; if ({got.bcd2, got.ovf2} !== {e.bcd2, e.ovf2}) begin errors++; $display("FAIL basic_d2 got=%h/%b want=%h/%b", got.bcd2, got.ovf2, e.bcd2, e.ovf2); end
        checks++; if (b3.done !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%b want=0", b3.done); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] vals[4];
        int done_at, busy_cnt; bit held; exp_t got, e;
        vals[0] = 8'd0; vals[1] = 8'd99; vals[2] = 8'd100; vals[3] = 8'd9;
        for (int n = 0; n < 4; n++) begin
            do_conv(vals[n], done_at, busy_cnt, held, got);
            e = sb.pop_front();
            checks++; if (done_at !== 9) begin errors++; $display("FAIL b2b_latency[%0d] got=%0d want=9", n, done_at); end
            checks++; if ({got.bcd3, got.ovf3} !== {e.bcd3, e.ovf3}) begin errors++; $display("FAIL b2b_d3[%0d] got=%h/%b want=%h/%b", n, got.bcd3, got.ovf3, e.bcd3, e.ovf3); end
            checks++; if ({got.bcd2, got.ovf2} !== {e.bcd2, e.ovf2}) begin errors++; $display("FAIL b2b_d2[%0d] got=%h/%b want=%h/%b", n, got.bcd2, got.ovf2, e.bcd2, e.ovf2); end
        end
    endtask

    task automatic test_ignore_start;
        int done_at, done_cnt; exp_t e;
        logic [11:0] r3;
        b3.start = 1'b1; b3.bin_in = 8'd10;
        sb.push_back(model(8'd10));
        @(negedge clk);
        b3.start = 1'b0;
        done_at = -1; done_cnt = 0; r3 = 'x;
        for (int i = 1; i <= 25; i++) begin
            if (i == 3) begin b3.start = 1'b1; b3.bin_in = 8'd200; end
            else begin b3.start = 1'b0; end
            if (b3.done) begin
                done_cnt++;
                if (done_at < 0) begin done_at = i; r3 = b3.bcd_out; end
            end
            @(negedge clk);
        end
        b3.start = 1'b0;
        e = sb.pop_front();
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d want=1", done_cnt); end
        checks++; if (r3 !== e.bcd3) begin errors++; $display("FAIL ignore_result got=%h want=%h", r3, e.bcd3); end
        checks++; if (b3.bcd_out !== e.bcd3) begin errors++; $display("FAIL ignore_final got=%h want=%h", b3.bcd_out, e.bcd3); end
    endtask

    task automatic test_signed;
        logic [7:0] vals[3];
        int done_at, busy_cnt; bit held; exp_t got, e;
        vals[0] = 8'h80; vals[1] = 8'hFF; vals[2] = 8'h7F;
        for (int n = 0; n < 3; n++) begin
            do_conv(vals[n], done_at, busy_cnt, held, got);
            e = sb.pop_front();
            checks++; if ({got.bcd3, got.ovf3} !== {e.bcd3, e.ovf3}) begin errors++; $display("FAIL sign_d3[%0d] got=%h/%b want=%h/%b", n, got.bcd3, got.ovf3, e.bcd3, e.ovf3); end
            checks++; if ({got.bcd2, got.ovf2} !== {e.bcd2, e.ovf2}) begin errors++; $display("FAIL sign_d2[%0d] got=%h/%b want=%h/%b", n, got.bcd2, got.ovf2, e.bcd2, e.ovf2); end
`ifdef SIGNED_INPUT_EN
            checks++; if (got.neg !== e.neg) begin errors++; $display("FAIL sign_neg[%0d] got=%b want=%b", n, got.neg, e.neg); end
`endif
        end
    endtask

    task automatic test_abort;
        int done_cnt, done_at, busy_cnt; bit held; exp_t got, e;
        b3.start = 1'b1; b3.bin_in = 8'd128;
        @(negedge clk);
        b3.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (b3.busy !== 1'b0 || b3.done !== 1'b0) begin errors++; $display("FAIL abort_flags got=%b%b want=00", b3.busy, b3.done); end
        checks++; if (b3.bcd_out !== 12'h000 || b3.overflow !== 1'b0) begin errors++; $display("FAIL abort_out3 got=%h/%b want=000/0", b3.bcd_out, b3.overflow); end
        checks++; if (b2.bcd_out !== 8'h00 || b2.overflow !== 1'b0) begin errors++; $display("FAIL abort_out2 got=%h/%b want=00/0", b2.bcd_out, b2.overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (b3.done || b3.busy) done_cnt++;
        end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done got=%0d want=0", done_cnt); end
        do_conv(8'd7, done_at, busy_cnt, held, got);
        e = sb.pop_front();
        checks++; if (done_at !== 9) begin errors++; $display("FAIL abort_restart_latency got=%0d want=9", done_at); end
        checks++; if ({got.bcd3, got.ovf3} !== {e.bcd3, e.ovf3}) begin errors++; $display("FAIL abort_restart got=%h/%b want=%h/%b", got.bcd3, got.ovf3, e.bcd3, e.ovf3); end
    endtask

    initial begin
        b3.start  = 1'b0;
        b3.bin_in = 8'd0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_back_to_back();
        repeat (2) @(negedge clk);
        test_ignore_start();
        test_signed();
        test_abort();
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
